// File: rtl/clk_ratio_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of clk_in in clk cycles,
// with lock and stall detection. Define CLK_RATIO_METER_SYNC_EN to add a 2-flop input synchronizer.
module clk_ratio_meter #(
  parameter int W        = 16,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         locked,
  output logic         timeout,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_MEAS  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] TOL_W   = W'(TOL);
  localparam logic [3:0]   LOCK_C  = 4'(LOCK_CNT);

  state_t       state;
  logic         s;
  logic         h;
  logic [W-1:0] cnt;
  logic [W-1:0] hi_lat;
  logic [3:0]   match_cnt;
  logic         first;

  logic         rise;
  logic         fall;
  logic [W-1:0] diff;
  logic         match;
  logic [3:0]   match_next;

`ifdef CLK_RATIO_METER_SYNC_EN
  // Synchronizer resets high so a line already high at reset release never looks like a rise.
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], clk_in};
  end
  assign s = sync_q[1];
`else
  assign s = clk_in;
`endif

  assign dbg_state = state;

  always_comb begin
    rise       = s & ~h;
    fall       = ~s & h;
    diff       = (cnt >= period) ? (cnt - period) : (period - cnt);
    match      = !first && (diff <= TOL_W);
    match_next = 4'd0;
    if (match) match_next = (match_cnt == LOCK_C) ? match_cnt : match_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT;
      h         <= 1'b1;
      cnt       <= '0;
      hi_lat    <= '0;
      match_cnt <= 4'd0;
      first     <= 1'b1;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      h     <= s;
      valid <= 1'b0;
      if (rise)                cnt <= W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + W'(1);

      case (state)
        S_WAIT: begin
          if (rise) begin
            state <= S_MEAS;
            first <= 1'b1;
          end
        end
        S_MEAS: begin
          if (rise) begin
            period    <= cnt;
            high_time <= hi_lat;
            valid     <= 1'b1;
            first     <= 1'b0;
            match_cnt <= match_next;
            locked    <= (match_next == LOCK_C);
          end else begin
            if (fall) hi_lat <= cnt;
            // Saturated counter with no rise: the input has stalled.
            if (cnt == CNT_MAX) begin
              state     <= S_STALL;
              timeout   <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= 4'd0;
            end
          end
        end
        S_STALL: begin
          if (rise) begin
            state   <= S_MEAS;
            timeout <= 1'b0;
            first   <= 1'b1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: three instances (default, TOL=2, W=8) share one stimulus.
module tb_clk_ratio_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_in;

  logic [15:0] period, high_time, period_t, high_time_t;
  logic [7:0]  period_8, high_time_8;
  logic        valid, locked, timeout;
  logic        valid_t, locked_t, timeout_t;
  logic        valid_8, locked_8, timeout_8;
  logic [1:0]  dbg_state, dbg_state_t, dbg_state_8;

  int n_tests = 0;
  int n_fail  = 0;

  // valid-event monitor state
  int          v_cnt = 0;
  int          v_cnt_8 = 0;
  logic [15:0] last_period = '0, last_high = '0;
  logic [7:0]  last_period_8 = '0, last_high_8 = '0;
  logic        tol_watch = 1'b0, tol_dropped = 1'b0, tol_prev = 1'b0;

  clk_ratio_meter #(.W(16), .LOCK_CNT(4), .TOL(0)) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .period(period), .high_time(high_time),
    .valid(valid), .locked(locked), .timeout(timeout), .dbg_state(dbg_state));

  clk_ratio_meter #(.W(16), .LOCK_CNT(4), .TOL(2)) dut_tol (
    .clk(clk), .rst(rst), .clk_in(clk_in), .period(period_t), .high_time(high_time_t),
    .valid(valid_t), .locked(locked_t), .timeout(timeout_t), .dbg_state(dbg_state_t));

  clk_ratio_meter #(.W(8), .LOCK_CNT(4), .TOL(0)) dut_w8 (
    .clk(clk), .rst(rst), .clk_in(clk_in), .period(period_8), .high_time(high_time_8),
    .valid(valid_8), .locked(locked_8), .timeout(timeout_8), .dbg_state(dbg_state_8));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst && valid) begin
      v_cnt++;
      last_period = period;
      last_high   = high_time;
    end
    if (!rst && valid_8) begin
      v_cnt_8++;
      last_period_8 = period_8;
      last_high_8   = high_time_8;
    end
    if (tol_watch && tol_prev && !locked_t) tol_dropped = 1'b1;
    tol_prev = locked_t;
  end

  // drivers: called at a negedge, return at a negedge
  task automatic pulse(input int hi, input int lo);
    clk_in = 1'b1;
    repeat (hi) @(negedge clk);
    clk_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic hold(input logic v, input int n);
    clk_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clk_in = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (period !== 16'd0)    begin n_fail++; $display("FAIL reset_period: got %0d expected 0", period); end
    n_tests++; if (high_time !== 16'd0) begin n_fail++; $display("FAIL reset_high: got %0d expected 0", high_time); end
    n_tests++; if (valid !== 1'b0)      begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_tests++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_tests++; if (timeout !== 1'b0)    begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_high_through_reset;
    rst = 1'b0;
    hold(1'b1, 20);
    hold(1'b0, 10);
    n_tests++; if (v_cnt !== 0)     begin n_fail++; $display("FAIL high_reset_valid: got %0d valids expected 0", v_cnt); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL high_reset_locked: got %b expected 0", locked); end
  endtask

  task automatic test_square;
    int base;
    base = v_cnt;
    pulse(5, 5);
    n_tests++; if (v_cnt - base !== 0) begin n_fail++; $display("FAIL square_first_rise: got %0d valids expected 0", v_cnt - base); end
    pulse(5, 5);
    n_tests++; if (v_cnt - base !== 1) begin n_fail++; $display("FAIL square_count1: got %0d valids expected 1", v_cnt - base); end
    n_tests++; if (last_period !== 16'd10) begin n_fail++; $display("FAIL square_period: got %0d expected 10", last_period); end
    n_tests++; if (last_high !== 16'd5)    begin n_fail++; $display("FAIL square_high: got %0d expected 5", last_high); end
    repeat (3) pulse(5, 5);
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL square_lock_early: got %b expected 0 after 4 valids", locked); end
    pulse(5, 5);
    n_tests++; if (v_cnt - base !== 5) begin n_fail++; $display("FAIL square_count5: got %0d valids expected 5", v_cnt - base); end
    n_tests++; if (locked !== 1'b1)    begin n_fail++; $display("FAIL square_lock: got %b expected 1 after 5 valids", locked); end
  endtask

  task automatic test_duty;
    n_tests++; if (locked_t !== 1'b1) begin n_fail++; $display("FAIL tol_locked_start: got %b expected 1", locked_t); end
    tol_prev  = locked_t;
    tol_watch = 1'b1;
    pulse(3, 7);
    pulse(3, 7);
    n_tests++; if (last_period !== 16'd10) begin n_fail++; $display("FAIL duty_period: got %0d expected 10", last_period); end
    n_tests++; if (last_high !== 16'd3)    begin n_fail++; $display("FAIL duty_high: got %0d expected 3", last_high); end
    n_tests++; if (locked !== 1'b1)        begin n_fail++; $display("FAIL duty_locked: got %b expected 1", locked); end
  endtask

  task automatic test_period_change;
    pulse(6, 6);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL change_pre_locked: got %b expected 1", locked); end
    pulse(6, 6);
    n_tests++; if (last_period !== 16'd12) begin n_fail++; $display("FAIL change_period: got %0d expected 12", last_period); end
    n_tests++; if (last_high !== 16'd6)    begin n_fail++; $display("FAIL change_high: got %0d expected 6", last_high); end
    n_tests++; if (locked !== 1'b0)        begin n_fail++; $display("FAIL change_drop: got %b expected 0", locked); end
    repeat (3) pulse(6, 6);
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL change_relock_early: got %b expected 0 after 3 matches", locked); end
    pulse(6, 6);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL change_relock: got %b expected 1 after 4 matches", locked); end
    n_tests++; if (tol_dropped !== 1'b0 || locked_t !== 1'b1)
      begin n_fail++; $display("FAIL tol2_lock_held: dropped=%b locked=%b expected dropped=0 locked=1", tol_dropped, locked_t); end
    tol_watch = 1'b0;
  endtask

  task automatic test_timeout;
    int waited;
    int base8;
    hold(1'b0, 230);
    n_tests++; if (timeout_8 !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", timeout_8); end
    waited = 0;
    while (timeout_8 !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_tests++; if (timeout_8 !== 1'b1) begin n_fail++; $display("FAIL timeout_set: got %b expected 1 within bound", timeout_8); end
    n_tests++; if (locked_8 !== 1'b0)  begin n_fail++; $display("FAIL timeout_locked: got %b expected 0", locked_8); end
    n_tests++; if (timeout !== 1'b0)   begin n_fail++; $display("FAIL timeout_w16: got %b expected 0", timeout); end
    base8 = v_cnt_8;
    pulse(5, 5);
    n_tests++; if (timeout_8 !== 1'b0)    begin n_fail++; $display("FAIL timeout_clear: got %b expected 0", timeout_8); end
    n_tests++; if (v_cnt_8 - base8 !== 0) begin n_fail++; $display("FAIL timeout_no_valid: got %0d valids expected 0", v_cnt_8 - base8); end
    pulse(5, 5);
    n_tests++; if (v_cnt_8 - base8 !== 1) begin n_fail++; $display("FAIL timeout_next_valid: got %0d valids expected 1", v_cnt_8 - base8); end
    n_tests++; if (last_period_8 !== 8'd10 || last_high_8 !== 8'd5)
      begin n_fail++; $display("FAIL timeout_next_meas: got period=%0d high=%0d expected 10/5", last_period_8, last_high_8); end
  endtask

  task automatic test_reset_mid;
    int base;
    repeat (4) pulse(5, 5);
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL mid_pre_locked: got %b expected 1", locked); end
    clk_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++; if (period !== 16'd0 || high_time !== 16'd0)
      begin n_fail++; $display("FAIL mid_async_meas: got period=%0d high=%0d expected 0/0", period, high_time); end
    n_tests++; if (locked !== 1'b0 || valid !== 1'b0 || timeout !== 1'b0)
      begin n_fail++; $display("FAIL mid_async_flags: got locked=%b valid=%b timeout=%b expected 0", locked, valid, timeout); end
    @(negedge clk);
    rst = 1'b0;
    base = v_cnt;
    hold(1'b1, 3);
    hold(1'b0, 5);
    pulse(5, 5);
    n_tests++; if (v_cnt - base !== 0) begin n_fail++; $display("FAIL mid_wait_no_valid: got %0d valids expected 0", v_cnt - base); end
    pulse(5, 5);
    n_tests++; if (v_cnt - base !== 1 || last_period !== 16'd10)
      begin n_fail++; $display("FAIL mid_restart: got %0d valids period=%0d expected 1/10", v_cnt - base, last_period); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_restart_locked: got %b expected 0", locked); end
  endtask

  initial begin
    rst = 1'b1;
    clk_in = 1'b1;
    @(negedge clk);
    test_reset;
    test_high_through_reset;
    test_square;
    test_duty;
    test_period_change;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_ratio_meter.md
# clk_ratio_meter

Measures a divided or slower clock-like signal against the system clock. Counts system-clock cycles between consecutive rising edges of the monitored input and reports period and high time. Declares lock once the period is stable, and flags a stalled input. It sits on the receiving side of the frequency-divider outputs and is used for on-chip checking of divider ratio and duty cycle.

## Interface
- W, 16: width of the period and high-time counters and outputs.
- LOCK_CNT, 4: consecutive matching periods required to assert `locked`; range 1..15.
- TOL, 0: maximum absolute period difference, in clk cycles, still counted as a match.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- clk_in  in  1  monitored signal.
- period  out  W  last measured rise-to-rise distance in clk cycles.
- high_time  out  W  last measured rise-to-fall distance in clk cycles.
- valid  out  1  one-cycle pulse when `period` and `high_time` update.
- locked  out  1  period stable within TOL for LOCK_CNT consecutive measurements.
- timeout  out  1  counter saturated with no rising edge; held until the next rising edge.

## Operation
- Sampled signal `s`: `clk_in` after the optional synchronizer (see Configuration). History register `h` holds the previous `s`.
  - `h` resets to 1, so an input already high at reset release does not produce a rise.
- Edges:
  - rise = s & ~h.
  - fall = ~s & h.
- Free counter `cnt` (W bits):
  - Cleared to 1 on a rise cycle.
  - Otherwise increments by 1 and saturates at 2^W-1.
  - At a rise, `cnt` equals the number of clk cycles since the previous rise.
- FSM states: WAIT, MEAS, STALL. Reset state is WAIT.
  - WAIT: on rise -> MEAS, `cnt` restarts, no output update.
  - MEAS:
    - On fall, latch `cnt` into internal `hi_lat`.
    - On rise, load `period`<=cnt and `high_time`<=hi_lat, pulse `valid`, then run the lock update.
    - If `cnt` reaches 2^W-1 with no rise -> STALL: `timeout`<=1, `locked`<=0, match counter <=0.
  - STALL: on rise -> MEAS, `timeout`<=0, `cnt` restarts. The partial period is discarded and no `valid` is issued.
- Lock update, on each `valid`:
  - Match when |cnt - period_prev| <= TOL, where period_prev is the `period` register before the update. Use unsigned compare on the W-bit values, with the difference formed as larger minus smaller.
  - On a match, the 4-bit match counter increments, saturating at LOCK_CNT.
  - On a mismatch, the match counter clears to 0.
  - The first `valid` after WAIT or STALL always counts as a mismatch.
  - `locked` = (match counter == LOCK_CNT), registered.
- Reset mid-measurement returns to WAIT immediately; everything below clears.
- Reset values: `period`=0, `high_time`=0, `valid`=0, `locked`=0, `timeout`=0, `cnt`=0, match counter=0, `hi_lat`=0.

## Timing
- A rise is detected in the cycle `s` first reads 1 after `h`=0.
- Outputs are registered. `period`, `high_time`, `valid`, `locked` and `timeout` change on the clk edge that ends the detect cycle.
- Input-to-`valid` latency from a `clk_in` transition:
  - 3 clk cycles with the synchronizer.
  - 1 clk cycle without it.
- `valid` is high for exactly one cycle per measured period and is never asserted in WAIT or STALL.
- Lock from a clean start takes LOCK_CNT+1 `valid` pulses: the first pulse is a forced mismatch.
- Minimum measurable period is 2 clk cycles.
- Pulses shorter than one clk cycle may be missed; the measurement is then of the sampled waveform.

## Configuration
- CLK_RATIO_METER_SYNC_EN:
  - Defined: `clk_in` passes through a 2-flop synchronizer (reset to 1) before `s`. Safe for asynchronous inputs; adds 2 cycles of latency.
  - Undefined: `s` = `clk_in` directly. Legal only when `clk_in` is generated synchronously to `clk`.

## Test plan
- Square wave, 5 cycles high and 5 low, from reset -> first `valid` at the second rise with `period`=10 and `high_time`=5; `locked`=1 on the 5th `valid` (LOCK_CNT=4).
- Duty change, 3 high and 7 low -> `period`=10, `high_time`=3, `locked` stays 1.
- Period changes from 10 to 12 with TOL=0 -> `locked` drops on that `valid`; it reasserts after 4 further `valid` pulses at 12. Repeat with TOL=2 -> `locked` never drops.
- Input held low with W=8 -> `timeout`=1 after 255 counted cycles, `locked`=0; the next rise clears `timeout` without a `valid`; the following rise gives a correct `valid`.
- `clk_in` high through reset release -> no `valid` and no lock activity until a genuine low-to-high transition.
- Assert `rst` mid-period while locked -> all outputs 0 asynchronously; measurement restarts in WAIT after release.
